// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fpu_pkg
// Brief   : Shared types and sizing helpers for the FPU normalizer.
// Rev     : 1.0
// ============================================================================
package fpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } norm_state_t;

  localparam int MANT_W_DEF = 53;
  localparam int EXP_W_DEF  = 11;
  localparam int STEP_DEF   = 8;

  // Width able to hold a leading-zero count of 0..mant_w inclusive.
  function automatic int shift_cnt_w(input int mant_w);
    return $clog2(mant_w) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_normalizer_lzc.sv
`default_nettype none
// ============================================================================
// Module  : lzc
// Brief   : Combinational leading-zero counter; all-zero input returns W.
// Rev     : 1.0
// ============================================================================
module lzc #(
  parameter int W    = 53,
  parameter int LZ_W = 7
) (
  input  logic [W-1:0]    i_data,
  output logic [LZ_W-1:0] o_lz
);

  // Scanning upward lets the highest set bit make the final assignment.
  always_comb begin
    o_lz = LZ_W'(W);
    for (int i = 0; i < W; i++) begin
      if (i_data[i]) o_lz = LZ_W'(W - 1 - i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp_normalizer.sv
`default_nettype none
// ============================================================================
// Module  : fp_normalizer
// Brief   : Multi-cycle post-add normalizer with carry fix and flag logic.
// Rev     : 1.0
// ============================================================================
module fp_normalizer
  import fpu_pkg::*;
#(
  parameter int MANT_W = MANT_W_DEF,
  parameter int EXP_W  = EXP_W_DEF,
  parameter int STEP   = STEP_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [MANT_W:0]   i_mant,
  input  logic [EXP_W-1:0]  i_exp,
  input  logic              i_sign,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [MANT_W-1:0] o_mant,
  output logic [EXP_W-1:0]  o_exp,
  output logic              o_sign,
  output logic              o_sticky,
  output logic              o_zero,
  output logic              o_overflow,
  output logic              o_underflow
);

  localparam int SHW = shift_cnt_w(MANT_W);
  localparam int CW  = (EXP_W + 1 > SHW) ? EXP_W + 1 : SHW;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [SHW-1:0]   STEP_C   = SHW'(STEP);

  norm_state_t       state_q, state_d;
  logic [MANT_W:0]   mant_q, mant_d;
  logic [EXP_W:0]    exp_q, exp_d;
  logic              sign_q, sign_d;
  logic [SHW-1:0]    rem_q, rem_d;
  logic [EXP_W-1:0]  fexp_q, fexp_d;
  logic              unf_q, unf_d;
  logic              valid_q, valid_d;
  logic [MANT_W-1:0] out_mant_q, out_mant_d;
  logic [EXP_W-1:0]  out_exp_q, out_exp_d;
  logic              out_sign_q, out_sign_d;
  logic              sticky_q, sticky_d;
  logic              zero_q, zero_d;
  logic              ovf_q, ovf_d;
  logic              unf_out_q, unf_out_d;

  logic [SHW-1:0]    lz;
  logic [CW-1:0]     lz_w, exp_w, limit_w, shift_total, final_exp;
  logic [EXP_W:0]    exp_inc;
  logic [SHW-1:0]    step_k;
  logic [MANT_W-1:0] mant_shl;
  logic              lz_over;

  lzc #(.W(MANT_W), .LZ_W(SHW)) u_lzc (
    .i_data (mant_q[MANT_W-1:0]),
    .o_lz   (lz)
  );

  // Exponent math is one bit wider than EXP_W so compares never wrap.
  always_comb begin
    lz_w              = '0;
    lz_w[SHW-1:0]     = lz;
    exp_w             = '0;
    exp_w[EXP_W:0]    = exp_q;
    limit_w           = (exp_w == '0) ? '0 : exp_w - CW'(1);
    lz_over           = lz_w > limit_w;
    shift_total       = lz_over ? limit_w : lz_w;
    final_exp         = lz_over ? '0 : exp_w - lz_w;
    exp_inc           = exp_q + (EXP_W+1)'(1);
    step_k            = (rem_q > STEP_C) ? STEP_C : rem_q;
    mant_shl          = mant_q[MANT_W-1:0] << step_k;
  end

  always_comb begin
    state_d    = state_q;
    mant_d     = mant_q;
    exp_d      = exp_q;
    sign_d     = sign_q;
    rem_d      = rem_q;
    fexp_d     = fexp_q;
    unf_d      = unf_q;
    valid_d    = valid_q;
    out_mant_d = out_mant_q;
    out_exp_d  = out_exp_q;
    out_sign_d = out_sign_q;
    sticky_d   = sticky_q;
    zero_d     = zero_q;
    ovf_d      = ovf_q;
    unf_out_d  = unf_out_q;

    case (state_q)
      IDLE: begin
        if (i_valid) begin
          mant_d  = i_mant;
          exp_d   = {1'b0, i_exp};
          sign_d  = i_sign;
          state_d = EVAL;
        end
      end

      EVAL: begin
        state_d    = DONE;
        valid_d    = 1'b1;
        out_sign_d = sign_q;
        sticky_d   = 1'b0;
        zero_d     = 1'b0;
        ovf_d      = 1'b0;
        unf_out_d  = 1'b0;
        if (mant_q == '0) begin
          out_mant_d = '0;
          out_exp_d  = '0;
          zero_d     = 1'b1;
        end else if (mant_q[MANT_W]) begin
          sticky_d = mant_q[0];
          if (exp_q[EXP_W-1:0] == EXP_ONES || exp_inc[EXP_W-1:0] == EXP_ONES) begin
            out_mant_d = '0;
            out_exp_d  = EXP_ONES;
            ovf_d      = 1'b1;
          end else begin
            out_mant_d = mant_q[MANT_W:1];
            out_exp_d  = exp_inc[EXP_W-1:0];
          end
        end else if (shift_total == '0) begin
          out_mant_d = mant_q[MANT_W-1:0];
          out_exp_d  = final_exp[EXP_W-1:0];
          unf_out_d  = lz_over;
        end else begin
          // Output registers stay untouched until the shift completes.
          state_d    = SHIFT;
          valid_d    = 1'b0;
          out_sign_d = out_sign_q;
          sticky_d   = sticky_q;
          zero_d     = zero_q;
          ovf_d      = ovf_q;
          unf_out_d  = unf_out_q;
          rem_d      = shift_total[SHW-1:0];
          fexp_d     = final_exp[EXP_W-1:0];
          unf_d      = lz_over;
        end
      end

      SHIFT: begin
        mant_d = {1'b0, mant_shl};
        rem_d  = rem_q - step_k;
        if (rem_q == step_k) begin
          state_d    = DONE;
          valid_d    = 1'b1;
          out_mant_d = mant_shl;
          out_exp_d  = fexp_q;
          out_sign_d = sign_q;
          sticky_d   = 1'b0;
          zero_d     = 1'b0;
          ovf_d      = 1'b0;
          unf_out_d  = unf_q;
        end
      end

      DONE: begin
        if (i_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      mant_q     <= '0;
      exp_q      <= '0;
      sign_q     <= 1'b0;
      rem_q      <= '0;
      fexp_q     <= '0;
      unf_q      <= 1'b0;
      valid_q    <= 1'b0;
      out_mant_q <= '0;
      out_exp_q  <= '0;
      out_sign_q <= 1'b0;
      sticky_q   <= 1'b0;
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
      unf_out_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mant_q     <= mant_d;
      exp_q      <= exp_d;
      sign_q     <= sign_d;
      rem_q      <= rem_d;
      fexp_q     <= fexp_d;
      unf_q      <= unf_d;
      valid_q    <= valid_d;
      out_mant_q <= out_mant_d;
      out_exp_q  <= out_exp_d;
      out_sign_q <= out_sign_d;
      sticky_q   <= sticky_d;
      zero_q     <= zero_d;
      ovf_q      <= ovf_d;
      unf_out_q  <= unf_out_d;
    end
  end

  assign o_ready     = (state_q == IDLE);
  assign o_valid     = valid_q;
  assign o_mant      = out_mant_q;
  assign o_exp       = out_exp_q;
  assign o_sign      = out_sign_q;
  assign o_sticky    = sticky_q;
  assign o_zero      = zero_q;
  assign o_overflow  = ovf_q;
  assign o_underflow = unf_out_q;

endmodule
`default_nettype wire
